cb: RTL and testbench
=====================

CB -- requirements
Module: cb

Interface
REQ-001 The clock port SHALL be clk, input, 1 bit; all state updates occur on its rising edge.
REQ-002 The reset port SHALL be rst, input, 1 bit; reset is synchronous and active-high.
REQ-003 Port a SHALL be an input, 1 bit, multiplicand bit.
REQ-004 Port b SHALL be an input, 1 bit, multiplier bit.
REQ-005 Port d SHALL be an input, 1 bit, partial-sum bit from the previous array row.
REQ-006 Port cin SHALL be an input, 1 bit, carry-in from the neighbouring cell.
REQ-007 Port in_valid SHALL be an input, 1 bit, qualifying a, b, d and cin in the current cycle.
REQ-008 Port sum SHALL be an output, 1 bit, cell sum bit.
REQ-009 Port cout SHALL be an output, 1 bit, cell carry-out bit.
REQ-010 Port out_valid SHALL be an output, 1 bit, qualifying sum and cout.
REQ-011 Port order in the port list SHALL be sum, cout, d, a, b, cin, followed by clk, rst, in_valid, out_valid.

Function
REQ-012 The cell SHALL form the partial product pp = a AND b.
REQ-013 The cell SHALL full-add pp, d and cin: sum_n = pp XOR d XOR cin; cout_n = majority(pp, d, cin).
REQ-014 The arithmetic identity 2*cout_n + sum_n = pp + d + cin SHALL hold for all 16 input combinations.
REQ-015 With d=0: sum_n = (a AND b) XOR cin; cout_n = a AND b AND cin.
REQ-016 With in_valid=1 at a rising edge, sum, cout and out_valid=1 SHALL present that cycle's result after that edge (latency 1 cycle).
REQ-017 With in_valid=0 at a rising edge, sum and cout SHALL hold their previous values and out_valid SHALL go to 0.
REQ-018 Inputs that change between edges SHALL have no effect on the outputs until the next rising edge.
REQ-019 No X SHALL propagate to the outputs after the first reset cycle when inputs are driven with known values.

Reset
REQ-020 While rst=1 at a rising edge, sum, cout and out_valid SHALL all be 0 after that edge, regardless of in_valid.
REQ-021 rst SHALL take priority over in_valid in the same cycle.
REQ-022 Reset asserted mid-stream SHALL discard any pending result; the first valid result after reset release SHALL follow the first in_valid=1 cycle with rst=0.

Configuration
REQ-023 Macro CB_COMB_BYPASS_EN SHALL select the output timing.
REQ-024 With CB_COMB_BYPASS_EN defined: sum = sum_n and cout = cout_n combinationally (zero latency); out_valid = in_valid AND NOT rst; clk is unused.
REQ-025 With CB_COMB_BYPASS_EN undefined: the registered behaviour of REQ-016 to REQ-022 SHALL apply.

Verification
REQ-026 Hold rst=1 for 2 cycles with a=b=d=cin=1 and in_valid=1 -> sum=0, cout=0, out_valid=0.
REQ-027 With d=0, sweep (cin,a,b) 000..111 with in_valid=1, one vector per cycle -> sum sequence 0,0,0,1,1,1,1,0 and cout sequence 0,0,0,0,0,0,0,1, each one cycle after its input.
REQ-028 Sweep all 16 combinations of a,b,d,cin -> 2*cout+sum equals (a AND b)+d+cin for every vector.
REQ-029 Apply a=b=cin=1, d=1 with in_valid=1, then in_valid=0 for 3 cycles with a=0 -> sum=1, cout=1 held, out_valid 1 then 0.
REQ-030 Assert rst for 1 cycle while in_valid=1 and a=b=cin=1 -> outputs 0 next cycle; the next in_valid=1 cycle restores normal results.
REQ-031 Build with CB_COMB_BYPASS_EN defined, a=b=1, d=0, cin=1 -> sum=0, cout=1 with no clock edge required.

Source files
------------

// File: rtl/cb.sv
// Carry-save multiplier array cell: partial product a&b full-added with d and cin.
// Define CB_COMB_BYPASS_EN for a purely combinational cell; default registers the result.
module cb (
    output logic sum,
    output logic cout,
    input  logic d,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic out_valid
);

    logic pp;
    logic sum_n;
    logic cout_n;

    always_comb begin
        pp     = a & b;
        sum_n  = pp ^ d ^ cin;
        cout_n = (pp & d) | (pp & cin) | (d & cin);
    end

`ifdef CB_COMB_BYPASS_EN

    // The clock only exists to keep the port list identical across builds.
    logic unused_clk;
    assign unused_clk = clk;

    assign sum       = sum_n;
    assign cout      = cout_n;
    assign out_valid = in_valid & ~rst;

`else

    // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    // NOTE: non-blocking assignments for every register so all state updates happen together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= 1'b0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= sum_n;
            cout      <= cout_n;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_cb.sv
// Self-checking bench for cb: a driver pushes expected responses into a queue and a monitor
// pops and compares them; the combinational build is checked directly when CB_COMB_BYPASS_EN is defined.
module tb_cb;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic d;
    logic cin;
    logic in_valid;
    logic sum;
    logic cout;
    logic out_valid;

    int vectors     = 0;
    int miscompares = 0;

    cb dut (
        .sum      (sum),
        .cout     (cout),
        .d        (d),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: {sum,cout,out_valid} got %b expected %b", name, act, exp);
        end
    endtask

    // Arithmetic reference: the cell adds three one-bit values (a*b, d, cin).
    function automatic logic [1:0] add_ref(input logic aa, input logic bb, input logic dd, input logic cc);
        int total;
        total = int'(aa & bb) + int'(dd) + int'(cc);
        return 2'(total);
    endfunction

`ifdef CB_COMB_BYPASS_EN

    initial begin
        logic [1:0] r;
        rst = 1'b0; in_valid = 1'b1;
        a = 1'b1; b = 1'b1; d = 1'b0; cin = 1'b1;
        #1;
        check("bypass_a1b1d0c1", {sum, cout, out_valid}, 3'b011);
        for (int i = 0; i < 16; i++) begin
            a = i[3]; b = i[2]; d = i[1]; cin = i[0];
            in_valid = i[0] ^ i[3];
            rst = (i == 5);
            #1;
            r = add_ref(a, b, d, cin);
            check($sformatf("bypass_sweep_%0d", i), {sum, cout, out_valid},
                  {r[0], r[1], in_valid & ~rst});
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

`else

    typedef struct {
        logic [2:0] resp;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural state of the reference: last presented result.
    logic m_sum  = 1'b0;
    logic m_cout = 1'b0;

    task automatic apply(input logic r, input logic v, input logic aa, input logic bb,
                         input logic dd, input logic cc, input string tag);
        exp_t       e;
        logic       valid;
        logic [1:0] res;
        @(negedge clk);
        rst = r; in_valid = v; a = aa; b = bb; d = dd; cin = cc;
        res = add_ref(aa, bb, dd, cc);
        if (r) begin
            m_sum = 1'b0; m_cout = 1'b0; valid = 1'b0;
        end else if (v) begin
            m_sum = res[0]; m_cout = res[1]; valid = 1'b1;
        end else begin
            valid = 1'b0;
        end
        e.resp = {m_sum, m_cout, valid};
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge consumes the expectation issued for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, {sum, cout, out_valid}, e.resp);
            end
        end
    end

    initial begin
        logic [3:0] v;
        rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; d = 1'b1; cin = 1'b1;

        apply(1, 1, 1, 1, 1, 1, "reset_0");
        apply(1, 1, 1, 1, 1, 1, "reset_1");

        for (int i = 0; i < 8; i++) begin
            v = 4'(i);
            apply(0, 1, v[1], v[0], 0, v[2], $sformatf("d0_sweep_%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            apply(0, 1, v[3], v[2], v[1], v[0], $sformatf("full_sweep_%0d", i));
        end

        apply(0, 1, 1, 1, 1, 1, "hold_load");
        for (int i = 0; i < 3; i++)
            apply(0, 0, 0, 1, 1, 1, $sformatf("hold_%0d", i));

        apply(0, 1, 0, 1, 1, 0, "pre_midreset");
        apply(1, 1, 1, 1, 0, 1, "midreset");
        apply(0, 1, 1, 1, 0, 1, "post_midreset");

        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(15) == 0), ($urandom_range(3) != 0),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $sformatf("rand_%0d", i));
            // Inputs wiggle between edges; only the values present at the edge may matter.
            @(posedge clk);
            #3;
            a = 1'($urandom); b = 1'($urandom); d = 1'($urandom);
            cin = 1'($urandom); in_valid = 1'($urandom); rst = 1'($urandom);
        end

        // Restore the last applied values are irrelevant; drain the queue with a bounded wait.
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d expectations pending, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

`endif

endmodule
